// File: rtl/nanorv32_ahb_arbiter.sv
// Two-master to one-slave AHB-lite arbiter: data bus (M0) has priority,
// fetch bus (M1) is protected from starvation; losers are buffered and replayed.
module nanorv32_ahb_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp
);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_M0   = 2'd1,
        SEL_M1   = 2'd2
    } sel_e;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [1:0]        trans;
    } aph_t;

    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    aph_t       pend0, pend1;
    aph_t       live0_ph, live1_ph;
    aph_t       src0, src1, cur;
    sel_e       aph_sel_r, dp_owner, sel;
    logic       lock_r;
    logic [3:0] wait_cnt;
    logic       live0, live1, req0, req1;

    always_comb begin
        m0_hready = pend0.v ? 1'b0 : ((dp_owner == SEL_M0) ? s_hready : 1'b1);
        m1_hready = pend1.v ? 1'b0 : ((dp_owner == SEL_M1) ? s_hready : 1'b1);
        live0 = m0_htrans[1] & m0_hready;
        live1 = m1_htrans[1] & m1_hready;
        req0  = pend0.v | live0;
        req1  = pend1.v | live1;
    end

    assign live0_ph = '{v: 1'b1, addr: m0_haddr, write: m0_hwrite,
                        size: m0_hsize, trans: m0_htrans};
    assign live1_ph = '{v: 1'b1, addr: m1_haddr, write: m1_hwrite,
                        size: m1_hsize, trans: m1_htrans};
    assign src0 = pend0.v ? pend0 : live0_ph;
    assign src1 = pend1.v ? pend1 : live1_ph;

    // While the slave stalls, the owner of the presented address phase is held.
    always_comb begin
        sel = SEL_NONE;
        if (lock_r && aph_sel_r != SEL_NONE)
            sel = aph_sel_r;
        else if (wait_cnt == WMAX && req1)
            sel = SEL_M1;
        else if (req0)
            sel = SEL_M0;
        else if (req1)
            sel = SEL_M1;
    end

    always_comb begin
        cur = '0;
        unique case (sel)
            SEL_M0:  cur = src0;
            SEL_M1:  cur = src1;
            default: cur = '0;
        endcase
        s_haddr  = cur.addr;
        s_htrans = cur.trans;
        s_hwrite = cur.write;
        s_hsize  = cur.size;
    end

    always_comb begin
        s_hwdata = '0;
        unique case (dp_owner)
            SEL_M0:  s_hwdata = m0_hwdata;
            SEL_M1:  s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    assign m0_hresp  = (dp_owner == SEL_M0) ? s_hresp : 1'b0;
    assign m1_hresp  = (dp_owner == SEL_M1) ? s_hresp : 1'b0;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend0     <= '0;
            pend1     <= '0;
            aph_sel_r <= SEL_NONE;
            dp_owner  <= SEL_NONE;
            lock_r    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            lock_r    <= ~s_hready;
            aph_sel_r <= sel;
            if (s_hready) begin
                dp_owner <= sel;
                if (sel == SEL_M0)
                    pend0.v <= 1'b0;
                if (sel == SEL_M1)
                    pend1.v <= 1'b0;
                if (sel == SEL_M1)
                    wait_cnt <= '0;
                else if (sel == SEL_M0 && req1 && wait_cnt != WMAX)
                    wait_cnt <= wait_cnt + 4'd1;
            end
            // A live request can only exist while its pending slot is empty.
            if (live0 && !(s_hready && sel == SEL_M0))
                pend0 <= live0_ph;
            if (live1 && !(s_hready && sel == SEL_M1))
                pend1 <= live1_ph;
        end
    end

endmodule

// File: tb/tb_nanorv32_ahb_arbiter.sv
// Directed and randomized checks of the AHB arbiter against a
// transaction-level model of grants, pending replays and data-phase owners.
module tb_nanorv32_ahb_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic [31:0] s_hrdata;
    logic        s_hready, s_hresp;

    logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
    logic        m0_hready, m1_hready, m0_hresp, m1_hresp, s_hwrite;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nanorv32_ahb_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .m0_haddr(haddr[0]), .m0_htrans(htrans[0]), .m0_hwrite(hwrite[0]),
        .m0_hsize(hsize[0]), .m0_hwdata(hwdata[0]), .m0_hrdata(m0_hrdata),
        .m0_hready(m0_hready), .m0_hresp(m0_hresp),
        .m1_haddr(haddr[1]), .m1_htrans(htrans[1]), .m1_hwrite(hwrite[1]),
        .m1_hsize(hsize[1]), .m1_hwdata(hwdata[1]), .m1_hrdata(m1_hrdata),
        .m1_hready(m1_hready), .m1_hresp(m1_hresp),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
        .s_hready(s_hready), .s_hresp(s_hresp)
    );

    // Reference model: per-master replay slot, held grant, data owner, starvation count.
    typedef struct {
        bit          v;
        logic [31:0] a;
        logic        w;
        logic [2:0]  sz;
        logic [1:0]  tr;
    } ph_t;

    ph_t mp [2];
    int  m_held, m_dp, m_starve;
    bit  e_rdy [2];
    bit  live  [2];
    int  e_g;
    ph_t e_ph;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) mp[n] = '{default: 0};
        m_held = -1;
        m_dp = -1;
        m_starve = 0;
        e_rdy[0] = 1'b1;
        e_rdy[1] = 1'b1;
    endtask

    task automatic model_eval();
        bit req [2];
        for (int n = 0; n < 2; n++) begin
            e_rdy[n] = mp[n].v ? 1'b0 : ((m_dp == n) ? s_hready : 1'b1);
            live[n]  = htrans[n][1] && e_rdy[n];
            req[n]   = mp[n].v || live[n];
        end
        if (m_held >= 0) e_g = m_held;
        else if (m_starve == MAXW && req[1]) e_g = 1;
        else if (req[0]) e_g = 0;
        else if (req[1]) e_g = 1;
        else e_g = -1;
        if (e_g < 0) e_ph = '{default: 0};
        else if (mp[e_g].v) e_ph = mp[e_g];
        else e_ph = '{v: 1'b1, a: haddr[e_g], w: hwrite[e_g],
                      sz: hsize[e_g], tr: htrans[e_g]};
    endtask

    task automatic model_check();
        chk("s_htrans", 64'(s_htrans), 64'(e_ph.tr));
        chk("s_haddr", 64'(s_haddr), 64'(e_ph.a));
        chk("s_hwrite", 64'(s_hwrite), 64'(e_ph.w));
        chk("s_hsize", 64'(s_hsize), 64'(e_ph.sz));
        chk("m0_hready", 64'(m0_hready), 64'(e_rdy[0]));
        chk("m1_hready", 64'(m1_hready), 64'(e_rdy[1]));
        chk("s_hwdata", 64'(s_hwdata), (m_dp < 0) ? 64'd0 : 64'(hwdata[m_dp]));
        chk("m0_hresp", 64'(m0_hresp), (m_dp == 0) ? 64'(s_hresp) : 64'd0);
        chk("m1_hresp", 64'(m1_hresp), (m_dp == 1) ? 64'(s_hresp) : 64'd0);
        chk("m0_hrdata", 64'(m0_hrdata), 64'(s_hrdata));
        chk("m1_hrdata", 64'(m1_hrdata), 64'(s_hrdata));
    endtask

    task automatic model_step();
        ph_t cap [2];
        bit  capv [2];
        bit  rq1;
        if (rst) begin
            model_reset();
        end else begin
            rq1 = mp[1].v || live[1];
            for (int n = 0; n < 2; n++) begin
                capv[n] = live[n] && !(s_hready && e_g == n);
                cap[n]  = '{v: 1'b1, a: haddr[n], w: hwrite[n],
                            sz: hsize[n], tr: htrans[n]};
            end
            if (s_hready) begin
                m_dp = e_g;
                if (e_g >= 0) mp[e_g].v = 1'b0;
                if (e_g == 1) m_starve = 0;
                else if (e_g == 0 && rq1 && m_starve < MAXW) m_starve++;
            end
            for (int n = 0; n < 2; n++)
                if (capv[n]) mp[n] = cap[n];
            m_held = (!s_hready && e_g >= 0) ? e_g : -1;
        end
    endtask

    task automatic settle();
        #4;
        model_eval();
        model_check();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_all();
        for (int n = 0; n < 2; n++) begin
            htrans[n] = 2'b00;
            haddr[n]  = '0;
            hwrite[n] = 1'b0;
            hsize[n]  = 3'd2;
            hwdata[n] = '0;
        end
        s_hready = 1'b1;
        s_hresp  = 1'b0;
        s_hrdata = 32'h1234_5678;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        settle();
        chk("rst_htrans", 64'(s_htrans), 64'd0);
        chk("rst_m0_hready", 64'(m0_hready), 64'd1);
        chk("rst_m1_hready", 64'(m1_hready), 64'd1);
        chk("rst_hwdata", 64'(s_hwdata), 64'd0);
        finish_cycle();
        rst = 1'b0;

        // Fetch only, back-to-back
        for (int k = 0; k < 3; k++) begin
            htrans[1] = (k == 0) ? 2'b10 : 2'b11;
            haddr[1]  = 32'(4 * k);
            settle();
            chk("m1only_addr", 64'(s_haddr), 64'(4 * k));
            chk("m1only_rdy", 64'(m1_hready), 64'd1);
            finish_cycle();
        end
        idle_all();
        settle();
        finish_cycle();

        // Collision: data wins, fetch replayed next cycle
        htrans[0] = 2'b10; haddr[0] = 32'h2000; hwrite[0] = 1'b1;
        htrans[1] = 2'b10; haddr[1] = 32'h0100;
        settle();
        chk("coll_first", 64'(s_haddr), 64'h2000);
        chk("coll_write", 64'(s_hwrite), 64'd1);
        finish_cycle();
        idle_all();
        hwdata[0] = 32'hCAFE_0001;
        settle();
        chk("coll_replay", 64'(s_haddr), 64'h0100);
        chk("coll_m1_stall", 64'(m1_hready), 64'd0);
        chk("coll_wdata", 64'(s_hwdata), 64'hCAFE_0001);
        finish_cycle();
        idle_all();
        settle();
        chk("coll_m1_done", 64'(m1_hready), 64'd1);
        finish_cycle();

        // Starvation guard: fetch wins on the fifth accept edge
        for (int k = 1; k <= 6; k++) begin
            htrans[0] = 2'b10; haddr[0] = 32'h3000 + 32'(4 * k);
            htrans[1] = 2'b10; haddr[1] = 32'h0400;
            settle();
            if (k == 5) chk("starve_m1", 64'(s_haddr), 64'h0400);
            else if (k == 6) chk("starve_m0_replay", 64'(s_haddr), 64'h3014);
            else chk("starve_m0", 64'(s_haddr), 64'h3000 + 64'(4 * k));
            finish_cycle();
        end
        idle_all();
        for (int k = 0; k < 2; k++) begin
            settle();
            finish_cycle();
        end

        // Slave wait states during an M0 data phase
        htrans[0] = 2'b10; haddr[0] = 32'h5000;
        settle();
        finish_cycle();
        htrans[0] = 2'b00;
        htrans[1] = 2'b10; haddr[1] = 32'h0200;
        s_hready = 1'b0;
        settle();
        chk("wait_addr0", 64'(s_haddr), 64'h0200);
        chk("wait_m0_lo0", 64'(m0_hready), 64'd0);
        chk("wait_m1_hi", 64'(m1_hready), 64'd1);
        finish_cycle();
        htrans[1] = 2'b00;
        for (int k = 1; k < 3; k++) begin
            settle();
            chk("wait_addr", 64'(s_haddr), 64'h0200);
            chk("wait_m0_lo", 64'(m0_hready), 64'd0);
            chk("wait_m1_lo", 64'(m1_hready), 64'd0);
            finish_cycle();
        end
        s_hready = 1'b1;
        settle();
        chk("wait_addr_acc", 64'(s_haddr), 64'h0200);
        chk("wait_m0_hi", 64'(m0_hready), 64'd1);
        chk("wait_m1_pend", 64'(m1_hready), 64'd0);
        finish_cycle();
        settle();
        chk("wait_m1_served", 64'(m1_hready), 64'd1);
        chk("wait_idle", 64'(s_htrans), 64'd0);
        finish_cycle();

        // Two-cycle ERROR response on a fetch
        htrans[1] = 2'b10; haddr[1] = 32'hFFFF_0000;
        settle();
        finish_cycle();
        htrans[1] = 2'b00;
        s_hresp = 1'b1; s_hready = 1'b0;
        settle();
        chk("err1_m1_resp", 64'(m1_hresp), 64'd1);
        chk("err1_m0_resp", 64'(m0_hresp), 64'd0);
        chk("err1_m1_rdy", 64'(m1_hready), 64'd0);
        finish_cycle();
        s_hready = 1'b1;
        settle();
        chk("err2_m1_resp", 64'(m1_hresp), 64'd1);
        chk("err2_m0_resp", 64'(m0_hresp), 64'd0);
        chk("err2_m1_rdy", 64'(m1_hready), 64'd1);
        finish_cycle();
        idle_all();
        settle();
        finish_cycle();

        // Reset while a fetch is pending behind a stalled slave
        htrans[0] = 2'b10; haddr[0] = 32'h5000;
        settle();
        finish_cycle();
        htrans[0] = 2'b00;
        htrans[1] = 2'b10; haddr[1] = 32'h0200;
        s_hready = 1'b0;
        settle();
        finish_cycle();
        htrans[1] = 2'b00;
        rst = 1'b1;
        settle();
        finish_cycle();
        rst = 1'b0;
        s_hready = 1'b1;
        settle();
        chk("rstmid_htrans", 64'(s_htrans), 64'd0);
        chk("rstmid_m0_rdy", 64'(m0_hready), 64'd1);
        chk("rstmid_m1_rdy", 64'(m1_hready), 64'd1);
        finish_cycle();
        settle();
        chk("rstmid_no_replay", 64'(s_htrans), 64'd0);
        finish_cycle();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (e_rdy[n]) begin
                    htrans[n] = ($urandom_range(0, 4) < 2) ? 2'b00
                                : 2'($urandom_range(2, 3));
                    haddr[n]  = $urandom & 32'hFFFF_FFFC;
                    hwrite[n] = 1'($urandom_range(0, 1));
                    hsize[n]  = 3'($urandom_range(0, 2));
                end
                hwdata[n] = $urandom;
            end
            s_hready = ($urandom_range(0, 3) != 0);
            s_hresp  = ($urandom_range(0, 7) == 0);
            s_hrdata = $urandom;
            rst      = ($urandom_range(0, 199) == 0);
            settle();
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
